// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule tables, types and 28-bit rotation helpers
package des_pkg;

  typedef logic [27:0] half_key_t;
  typedef logic [47:0] subkey_t;
  typedef enum logic {IDLE, GEN} state_t;

  // Entries are FIPS 46-3 1-based bit numbers, bit 1 being the MSB of the source word
  localparam logic [5:0] PC1 [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic half_key_t rol28(input half_key_t x, input logic [1:0] s);
    return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic half_key_t ror28(input half_key_t x, input logic [1:0] s);
    return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 selection from the 56-bit C/D state
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output subkey_t     sk_o
);

  for (genvar j = 0; j < 48; j++) begin : g_sel
    assign sk_o[47-j] = cd_i[6'(56 - int'(PC2[j]))];
  end

endmodule

// File: rtl/des_key_schedule_seq.sv
// rtl/des_key_schedule_seq.sv - sequential DES key schedule, one subkey beat per cycle
module des_key_schedule_seq
  import des_pkg::*;
#(
  parameter bit STORE_BANK = 1'b1,
  parameter bit OUT_REG    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] sk_data,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  input  logic [3:0]  rd_idx,
  output logic [47:0] rd_data,
  output logic        bank_valid
);

  state_t      st_q;
  half_key_t   c_q, d_q, c_d, d_d;
  logic [3:0]  cnt_q;
  logic        dir_q;
  logic [55:0] pc1_key;
  logic        key_acc, beat_acc;

  for (genvar j = 0; j < 56; j++) begin : g_pc1
    assign pc1_key[55-j] = key[6'(64 - int'(PC1[j]))];
  end

  assign key_ready = (st_q == IDLE);
  assign sk_valid  = (st_q == GEN);
  assign key_acc   = key_valid && key_ready;
  assign beat_acc  = sk_valid && sk_ready;
  assign sk_last   = sk_valid && (cnt_q == 4'd15);
  assign sk_round  = sk_valid ? (dir_q ? ~cnt_q : cnt_q) : 4'd0;

  // C/D always hold the state whose PC-2 is the beat currently presented
  always_comb begin
    c_d = c_q;
    d_d = d_q;
    if (key_acc) begin
      c_d = decrypt ? pc1_key[55:28] : rol28(pc1_key[55:28], SHIFT[0]);
      d_d = decrypt ? pc1_key[27:0]  : rol28(pc1_key[27:0], SHIFT[0]);
    end else if (beat_acc && !sk_last) begin
      if (dir_q) begin
        c_d = ror28(c_q, SHIFT[~cnt_q]);
        d_d = ror28(d_q, SHIFT[~cnt_q]);
      end else begin
        c_d = rol28(c_q, SHIFT[cnt_q + 4'd1]);
        d_d = rol28(d_q, SHIFT[cnt_q + 4'd1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      c_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      c_q <= c_d;
      d_q <= d_d;
      if (key_acc) begin
        st_q  <= GEN;
        cnt_q <= '0;
        dir_q <= decrypt;
      end else if (beat_acc) begin
        if (sk_last) st_q <= IDLE;
        else         cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  if (OUT_REG) begin : g_oreg
    subkey_t sk_next, sk_q;
    des_pc2 u_pc2 (.cd_i({c_d, d_d}), .sk_o(sk_next));
    always_ff @(posedge clk) begin
      if (rst)                       sk_q <= '0;
      else if (key_acc || beat_acc)  sk_q <= sk_next;
    end
    assign sk_data = sk_q;
  end else begin : g_ocomb
    des_pc2 u_pc2 (.cd_i({c_q, d_q}), .sk_o(sk_data));
  end

  if (STORE_BANK) begin : g_bank
    subkey_t bank_q [16];
    logic    bank_valid_q;
    always_ff @(posedge clk) begin
      if (!rst && beat_acc) bank_q[sk_round] <= sk_data;
    end
    always_ff @(posedge clk) begin
      if (rst || key_acc)           bank_valid_q <= 1'b0;
      else if (beat_acc && sk_last) bank_valid_q <= 1'b1;
    end
    assign rd_data    = bank_q[rd_idx];
    assign bank_valid = bank_valid_q;
  end else begin : g_nobank
    assign rd_data    = '0;
    assign bank_valid = 1'b0;
  end

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
Sequential DES key-schedule engine and successor to the all-combinational subkey generator.
- Accepts a 64-bit key through a valid/ready handshake.
- Emits the 16 48-bit round subkeys one per beat on a valid/ready stream, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Optionally retains all 16 subkeys in a register bank with a random-access read port.
- Sits between the key-load interface and the iterative DES round datapath.

Parameters:
- STORE_BANK, 1: 1 = instantiate the 16x48 subkey bank and read port; 0 = stream only, rd_data tied to 0, bank_valid tied to 0.
- OUT_REG, 1: 1 = subkey stream driven from an output register; 0 = stream driven combinationally from the C/D state registers (same handshake, no extra cycle).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  key offered
- key_ready  out  1  engine idle and able to accept a key
- key  in  64  DES key, FIPS 46-3 bit 1 = key[63]; parity bits ignored
- decrypt  in  1  sampled with key; 1 = emit K16 first
- sk_valid  out  1  subkey beat valid
- sk_ready  in  1  consumer accepts beat
- sk_data  out  48  subkey, PC-2 bit 1 = sk_data[47]
- sk_round  out  4  round index of the beat, 0..15 meaning K1..K16
- sk_last  out  1  final beat of the key
- rd_idx  in  4  bank read index, 0 = K1
- rd_data  out  48  bank[rd_idx], combinational
- bank_valid  out  1  bank holds a complete schedule for the last accepted key

Behaviour:
- Reset values: key_ready=1, sk_valid=0, sk_data=0, sk_round=0, sk_last=0, bank_valid=0, FSM=IDLE, bank contents don't-care.
- Key accept occurs on the cycle where key_valid && key_ready.
  - C/D <= PC-1(key).
  - dir <= decrypt.
  - step counter <= 0.
  - bank_valid <= 0.
  - FSM <= GEN.
- FSM states:
  - IDLE: key_ready=1, sk_valid=0.
  - GEN: key_ready=0, sk_valid=1.
  - IDLE->GEN on key accept; GEN->IDLE on the accepted beat with sk_last=1.
- Encrypt step n (0..15):
  - Before presenting the beat, C/D are rotated left by SHIFT[n].
  - SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - sk_data = PC-2(C,D); sk_round = n.
- Decrypt step n:
  - Step 0 presents PC-2 of the unrotated PC-1 state (equals K16, since the total rotation is 28).
  - After each accepted beat, C/D rotate right by SHIFT[15-n].
  - sk_round = 15-n.
- Latency:
  - OUT_REG=1: first sk_valid one cycle after key accept.
  - OUT_REG=0: rotation for encrypt step 0 is folded into the accept cycle, and sk_valid is still first high the cycle after accept.
  - Sustains 1 beat per cycle with sk_ready held high; 16 beats, then key_ready high the cycle after the last beat is accepted.
- Backpressure: while sk_valid && !sk_ready, sk_data, sk_round and sk_last hold stable and C/D and the counter do not advance.
- sk_last = (counter == 15).
- Bank (STORE_BANK=1):
  - Each accepted beat writes bank[sk_round] <= sk_data.
  - bank_valid <= 1 on the accepted sk_last beat.
  - rd_data is readable at any time, but only meaningful when bank_valid=1.
- Boundary conditions:
  - key_valid while busy is ignored (key_ready=0); the master holds it.
  - key_valid asserted in the same cycle as the last beat is accepted is NOT accepted; it is accepted the next cycle.
  - rst mid-GEN aborts immediately: the FSM returns to IDLE, all outputs go to reset values, and no further bank writes occur.
  - decrypt and key changing while busy have no effect.
- Widths: C and D are 28 bits each, rotation is modulo 28, and the counter is 4 bits with no wrap beyond 15.

Decomposition:
- Package des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries) as localparam arrays of 6-bit indices.
  - SHIFT schedule (16 x 2-bit).
  - Typedefs half_key_t [27:0] and subkey_t [47:0].
  - FSM state enum {IDLE, GEN}.
- Sub-module des_pc2: combinational PC-2 selection, 56-bit in, 48-bit out. It is reused by the round datapath's self-check.

Test Plan:
- Encrypt order:
  - Stimulus: key=0x133457799BBCDFF1, decrypt=0, sk_ready=1.
  - Required response: 16 consecutive beats starting one cycle after accept; beat 0 = 0x1B02EFFC7072 (round 0), beat 1 = 0x79AED9DBC9E5, beat 15 = 0xCB3D8B0E17F5 with sk_last=1.
- Decrypt order:
  - Stimulus: same key, decrypt=1.
  - Required response: beat 0 = 0xCB3D8B0E17F5 with sk_round=15; beat 15 = 0x1B02EFFC7072 with sk_round=0 and sk_last=1.
- Backpressure:
  - Stimulus: same key, sk_ready toggling randomly, including a 5-cycle stall on beat 3.
  - Required response: outputs stable during stalls, sequence identical to the unstalled run, no beat lost or duplicated.
- Bank:
  - Stimulus: after the encrypt run, sweep rd_idx 0..15.
  - Required response: bank_valid=1; rd_data[0]=0x1B02EFFC7072 and rd_data[15]=0xCB3D8B0E17F5; bank_valid drops the cycle after a new key is accepted.
- Reset and back-to-back:
  - Stimulus: assert rst after beat 6.
  - Required response: next cycle sk_valid=0, key_ready=1, bank_valid=0.
  - Stimulus: hold key_valid=1 across the sk_last acceptance.
  - Required response: the second key is accepted exactly one cycle after the last beat.
- Parity invariance:
  - Stimulus: key=0x133457799BBCDFF1 with all 8 LSB parity bits flipped (0x123556789ABDDEF0).
  - Required response: identical 16 subkeys.
